// File: rtl/seg_scan_pkg.sv
// Shared types and sizing helpers for the 7-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {S_BLANK, S_ON, S_GAP} state_t;

    // Slot counter width: wide enough for both the ON and GAP counts, never below 1 bit.
    function automatic int unsigned cnt_w(input int unsigned refresh_div,
                                          input int unsigned gap_cycles);
        int unsigned m;
        m = (refresh_div > gap_cycles) ? refresh_div : gap_cycles;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/seg_lzb_mask.sv
// Leading-zero blank mask: bit k is set when nibbles k..NUM_DIGITS-1 are all zero.
// Digit 0 is never blanked so a zero value still shows "0".
module seg_lzb_mask #(
    parameter int unsigned NUM_DIGITS = 6
) (
    input  logic [4*NUM_DIGITS-1:0] data_i,
    output logic [NUM_DIGITS-1:0]   mask_o
);

    always_comb begin
        logic zero_above;
        mask_o     = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above & (data_i[4*k +: 4] == 4'd0);
            mask_o[k]  = zero_above;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous double buffering.
// Optional feature: define LEADING_ZERO_BLANK_EN to also blank leading zero digits.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GAP_CYCLES  = 500
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [4*NUM_DIGITS-1:0] wr_data_i,
    input  logic [NUM_DIGITS-1:0]   wr_blank_i,
    output logic [NUM_DIGITS-1:0]   digit_sel_o,
    output logic [3:0]              bcd_o,
    output logic                    blank_o,
    output logic                    frame_done_o
);

    localparam int unsigned CW = cnt_w(REFRESH_DIV, GAP_CYCLES);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] ON_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d, idx_next;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         active_q, active_d, shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] active_blank_q, active_blank_d, shadow_blank_q, shadow_blank_d;
    logic                  pending_q, pending_d;
    logic                  ready_q, ready_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [3:0]            bcd_q, bcd_d;
    logic                  blank_q, blank_d;
    logic                  frame_done_q, frame_done_d;
    logic                  accept, boundary;
    logic [NUM_DIGITS-1:0] eff_blank;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;

    seg_lzb_mask #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_lzb_mask (
        .data_i (wr_data_i),
        .mask_o (lz_mask)
    );

    assign eff_blank = wr_blank_i | lz_mask;
`else
    assign eff_blank = wr_blank_i;
`endif

    // True on the last cycle of the final digit's slot (its GAP, or its ON when there is no gap).
    function automatic logic at_boundary(input state_t st, input logic [IW-1:0] ix,
                                         input logic [CW-1:0] ct);
        if (ix != IDX_LAST) return 1'b0;
        if (GAP_CYCLES == 0) return (st == S_ON) && (ct == ON_LAST);
        return (st == S_GAP) && (ct == GAP_LAST);
    endfunction

    always_comb begin
        accept         = wr_valid_i & ready_q;
        boundary       = at_boundary(state_q, idx_q, cnt_q);
        idx_next       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        active_d       = active_q;
        active_blank_d = active_blank_q;
        shadow_d       = shadow_q;
        shadow_blank_d = shadow_blank_q;
        pending_d      = pending_q;

        unique case (state_q)
            S_BLANK: begin
                if (accept) begin
                    state_d        = S_ON;
                    idx_d          = '0;
                    cnt_d          = '0;
                    active_d       = wr_data_i;
                    active_blank_d = eff_blank;
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d = '0;
                    if (GAP_CYCLES == 0) idx_d = idx_next;
                    else                 state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ON;
                    idx_d   = idx_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_BLANK;
        endcase

        if (boundary && pending_q) begin
            active_d       = shadow_q;
            active_blank_d = shadow_blank_q;
            pending_d      = 1'b0;
        end

        // An accept on the boundary cycle lands in shadow and waits for the next frame.
        if (accept && (state_q != S_BLANK)) begin
            shadow_d       = wr_data_i;
            shadow_blank_d = eff_blank;
            pending_d      = 1'b1;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        digit_sel_d  = '0;
        bcd_d        = 4'd0;
        blank_d      = 1'b1;
        if (state_d == S_ON) begin
            digit_sel_d = NUM_DIGITS'(1) << idx_d;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_d == IW'(k)) begin
                    bcd_d   = active_d[4*k +: 4];
                    blank_d = active_blank_d[k];
                end
            end
        end
        frame_done_d = at_boundary(state_d, idx_d, cnt_d);
        ready_d      = ~pending_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_BLANK;
            idx_q          <= '0;
            cnt_q          <= '0;
            active_q       <= '0;
            active_blank_q <= '0;
            shadow_q       <= '0;
            shadow_blank_q <= '0;
            pending_q      <= 1'b0;
            ready_q        <= 1'b0;
            digit_sel_q    <= '0;
            bcd_q          <= 4'd0;
            blank_q        <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            active_q       <= active_d;
            active_blank_q <= active_blank_d;
            shadow_q       <= shadow_d;
            shadow_blank_q <= shadow_blank_d;
            pending_q      <= pending_d;
            ready_q        <= ready_d;
            digit_sel_q    <= digit_sel_d;
            bcd_q          <= bcd_d;
            blank_q        <= blank_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign wr_ready_o   = ready_q;
    assign digit_sel_o  = digit_sel_q;
    assign bcd_o        = bcd_q;
    assign blank_o      = blank_q;
    assign frame_done_o = frame_done_q;

endmodule
